// File: rtl/sram_arbiter.sv
// sram_arbiter
//   Round-robin arbiter that lets NREQ requesters share one internal 64-bit SRAM port.
//   An IDLE cycle picks the next requester at or above rr_ptr. The winner then owns the
//   SRAM for a burst of beats until it marks a beat with i_last or drops i_req.
//
// Optional feature (compile-time macro):
//   SRAM_ARB_BURST_LIMIT_EN - when defined, an owner is also released on its MAX_BEATS-th
//                             accepted beat; when undefined, bursts are unbounded.
//
// Ports:
//   i_clk, i_rst                 clock; synchronous active-high reset
//   i_req/i_we/i_last [NREQ]     per-requester request, write enable, last-beat marker
//   i_addr/i_wdata/i_wstrb       per-requester address, write data, byte strobes (slice k)
//   o_gnt [NREQ]                 registered one-hot grant
//   o_rvalid [NREQ], o_rdata     registered one-hot read valid, shared read data
//   o_sram_*                     SRAM command (cs, we, addr, wdata, wstrb)
//   i_sram_rdata                 SRAM read data, one cycle after the cs cycle

module sram_arbiter #(
    parameter int unsigned NREQ      = 4,
    parameter int unsigned abits     = 18,
    parameter int unsigned MAX_BEATS = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [NREQ-1:0]       i_req,
    input  logic [NREQ-1:0]       i_we,
    input  logic [NREQ*abits-1:0] i_addr,
    input  logic [NREQ*64-1:0]    i_wdata,
    input  logic [NREQ*8-1:0]     i_wstrb,
    input  logic [NREQ-1:0]       i_last,
    output logic [NREQ-1:0]       o_gnt,
    output logic [NREQ-1:0]       o_rvalid,
    output logic [63:0]           o_rdata,
    output logic                  o_sram_cs,
    output logic                  o_sram_we,
    output logic [abits-1:0]      o_sram_addr,
    output logic [63:0]           o_sram_wdata,
    output logic [7:0]            o_sram_wstrb,
    input  logic [63:0]           i_sram_rdata
);

    localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned CW = $clog2(MAX_BEATS) + 1;

    typedef enum logic {
        StIdle,
        StBusy
    } state_t;

    state_t          state_q;
    logic [IW-1:0]   owner_q;
    logic [IW-1:0]   rr_ptr_q;
    logic [CW-1:0]   beat_cnt_q;
    logic [NREQ-1:0] gnt_q;
    logic [NREQ-1:0] rvalid_q;

    logic [IW-1:0]   winner;
    logic            busy;
    logic            own_req;
    logic            own_we;
    logic            own_last;
    logic            accept;
    logic            limit_hit;
    logic            release_now;
    logic [IW-1:0]   next_ptr;
    logic [CW-1:0]   beat_cnt_inc;

    // First requester at or above rr_ptr, wrapping modulo NREQ.
    always_comb begin
        int unsigned idx;
        logic        found;
        idx    = 0;
        found  = 1'b0;
        winner = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            idx = 32'(rr_ptr_q) + i;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (!found && i_req[IW'(idx)]) begin
                found  = 1'b1;
                winner = IW'(idx);
            end
        end
    end

    assign busy     = (state_q == StBusy);
    assign own_req  = i_req[owner_q];
    assign own_we   = i_we[owner_q];
    assign own_last = i_last[owner_q];
    assign accept   = busy && own_req;

`ifdef SRAM_ARB_BURST_LIMIT_EN
    assign limit_hit = (beat_cnt_q == CW'(MAX_BEATS - 1));
`else
    assign limit_hit = 1'b0;
`endif

    // An owner that stops requesting gives up the SRAM as well.
    assign release_now = (accept && (own_last || limit_hit)) || (busy && !own_req);
    assign next_ptr    = (owner_q == IW'(NREQ - 1)) ? '0 : owner_q + 1'b1;

    // Saturates so an unbounded burst never wraps the count.
    assign beat_cnt_inc = (beat_cnt_q == {CW{1'b1}}) ? beat_cnt_q : beat_cnt_q + 1'b1;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= StIdle;
            owner_q    <= '0;
            rr_ptr_q   <= '0;
            beat_cnt_q <= '0;
            gnt_q      <= '0;
            rvalid_q   <= '0;
        end else begin
            rvalid_q <= (accept && !own_we) ? (NREQ'(1) << owner_q) : '0;
            case (state_q)
                StIdle: begin
                    if (|i_req) begin
                        state_q    <= StBusy;
                        owner_q    <= winner;
                        gnt_q      <= NREQ'(1) << winner;
                        beat_cnt_q <= '0;
                    end
                end
                StBusy: begin
                    if (release_now) begin
                        state_q    <= StIdle;
                        gnt_q      <= '0;
                        rr_ptr_q   <= next_ptr;
                        beat_cnt_q <= '0;
                    end else if (accept) begin
                        beat_cnt_q <= beat_cnt_inc;
                    end
                end
            endcase
        end
    end

    assign o_gnt        = gnt_q;
    assign o_rvalid     = rvalid_q;
    assign o_rdata      = i_sram_rdata;
    assign o_sram_cs    = accept;
    assign o_sram_we    = accept && own_we;
    assign o_sram_addr  = i_addr[32'(owner_q) * abits +: abits];
    assign o_sram_wdata = i_wdata[32'(owner_q) * 64 +: 64];
    assign o_sram_wstrb = i_wstrb[32'(owner_q) * 8 +: 8];

endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter
//   Self-checking bench for sram_arbiter: directed scenarios followed by random traffic,
//   every cycle compared against a transaction-level reference model of the arbiter.
//   Honours SRAM_ARB_BURST_LIMIT_EN the same way as the design.

module tb_sram_arbiter;

    localparam int N    = 4;
    localparam int AB   = 18;
    localparam int MAXB = 16;
`ifdef SRAM_ARB_BURST_LIMIT_EN
    localparam bit LIMIT = 1'b1;
`else
    localparam bit LIMIT = 1'b0;
`endif

    logic              clk;
    logic              rst;
    logic [N-1:0]      req, we, last;
    logic [N*AB-1:0]   addr;
    logic [N*64-1:0]   wdata;
    logic [N*8-1:0]    wstrb;
    logic [N-1:0]      gnt, rvalid;
    logic [63:0]       rdata;
    logic              sram_cs, sram_we;
    logic [AB-1:0]     sram_addr;
    logic [63:0]       sram_wdata;
    logic [7:0]        sram_wstrb;
    logic [63:0]       sram_rdata;

    sram_arbiter #(.NREQ(N), .abits(AB), .MAX_BEATS(MAXB)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_req        (req),
        .i_we         (we),
        .i_addr       (addr),
        .i_wdata      (wdata),
        .i_wstrb      (wstrb),
        .i_last       (last),
        .o_gnt        (gnt),
        .o_rvalid     (rvalid),
        .o_rdata      (rdata),
        .o_sram_cs    (sram_cs),
        .o_sram_we    (sram_we),
        .o_sram_addr  (sram_addr),
        .o_sram_wdata (sram_wdata),
        .o_sram_wstrb (sram_wstrb),
        .i_sram_rdata (sram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_bad = 0;
    int cyc   = 0;
    bit armed = 1'b0;

    // Reference model: who owns the SRAM, the round-robin start point, beats so far.
    bit           m_busy;
    int           m_owner, m_ptr, m_beats;
    logic [N-1:0] m_gnt, m_rvalid;
    logic [63:0]  m_rdata;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [63:0] mem_val(input logic [AB-1:0] a);
        return {14'h1a5, a, ~a, 14'h2c3};
    endfunction

    task automatic idle_inputs();
        req  = '0;
        we   = '0;
        last = '0;
    endtask

    task automatic set_req(input int k, input bit w, input bit l, input logic [AB-1:0] a);
        req[k]            = 1'b1;
        we[k]             = w;
        last[k]           = l;
        addr[k*AB +: AB]  = a;
        wdata[k*64 +: 64] = {32'(k) + 32'hcafe_0000, 32'(a)};
        wstrb[k*8 +: 8]   = 8'(8'h11 << k);
    endtask

    // One clock: check command outputs, advance the model on the edge, check registered outputs.
    task automatic step();
        logic [N-1:0]    s_req, s_we, s_last;
        logic            s_rst, hit, rel, found, exp_cs;
        logic [N*AB-1:0] s_addr;
        logic [AB-1:0]   ha;
        int              k;
        #1;
        s_req  = req;
        s_we   = we;
        s_last = last;
        s_rst  = rst;
        s_addr = addr;
        if (armed) begin
            exp_cs = m_busy && s_req[m_owner];
            check("sram_cs", 64'(sram_cs), 64'(exp_cs));
            if (exp_cs) begin
                check("sram_we", 64'(sram_we), 64'(s_we[m_owner]));
                check("sram_addr", 64'(sram_addr), 64'(s_addr[m_owner*AB +: AB]));
                check("sram_wdata", sram_wdata, wdata[m_owner*64 +: 64]);
                check("sram_wstrb", 64'(sram_wstrb), 64'(wstrb[m_owner*8 +: 8]));
            end
        end
        hit = sram_cs && !sram_we;
        ha  = sram_addr;
        @(posedge clk);
        m_rvalid = '0;
        rel      = 1'b0;
        if (s_rst) begin
            m_busy = 0; m_owner = 0; m_ptr = 0; m_beats = 0; m_gnt = '0;
        end else if (!m_busy) begin
            found = 1'b0;
            for (int i = 0; i < N; i++) begin
                k = (m_ptr + i) % N;
                if (!found && s_req[k]) begin
                    found   = 1'b1;
                    m_owner = k;
                end
            end
            if (found) begin
                m_busy  = 1;
                m_beats = 0;
                m_gnt   = '0;
                m_gnt[m_owner] = 1'b1;
            end
        end else if (s_req[m_owner]) begin
            m_beats++;
            if (!s_we[m_owner]) begin
                m_rvalid[m_owner] = 1'b1;
                m_rdata = mem_val(s_addr[m_owner*AB +: AB]);
            end
            rel = s_last[m_owner] || (LIMIT && m_beats == MAXB);
        end else begin
            rel = 1'b1;
        end
        if (rel) begin
            m_busy  = 0;
            m_ptr   = (m_owner + 1) % N;
            m_gnt   = '0;
            m_beats = 0;
        end
        #1;
        sram_rdata = hit ? mem_val(ha) : {$urandom, $urandom};
        #1;
        armed = 1'b1;
        check("gnt", 64'(gnt), 64'(m_gnt));
        check("rvalid", 64'(rvalid), 64'(m_rvalid));
        if (m_rvalid != '0) check("rdata", rdata, m_rdata);
        cyc++;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    function automatic int onehot_idx(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return -1;
    endfunction

    initial begin
        int           cnt, ng, gidx[5], gcyc[5];
        bit           done, saw_g0;
        logic [N-1:0] prev;

        rst = 1'b0; idle_inputs();
        addr = '0; wdata = '0; wstrb = '0; sram_rdata = '0;
        m_busy = 0; m_owner = 0; m_ptr = 0; m_beats = 0; m_gnt = '0; m_rvalid = '0;
        m_rdata = '0;

        // Reset state.
        do_reset();
        check("rst_gnt", 64'(gnt), 64'd0);
        check("rst_rvalid", 64'(rvalid), 64'd0);
        check("rst_cs", 64'(sram_cs), 64'd0);
        check("rst_we", 64'(sram_we), 64'd0);

        // Single read by requester 2.
        set_req(2, 1'b0, 1'b1, 18'h100);
        step();
        check("rd_gnt", 64'(gnt), 64'b0100);
        check("rd_cs", 64'(sram_cs), 64'd1);
        check("rd_addr", 64'(sram_addr), 64'h100);
        step();
        idle_inputs();
        check("rd_rvalid", 64'(rvalid), 64'b0100);
        check("rd_data", rdata, mem_val(18'h100));
        step();

        // Four single-beat requesters held: round-robin with one bubble between owners.
        do_reset();
        for (int k = 0; k < N; k++) set_req(k, 1'b0, 1'b1, 18'(k * 8));
        prev = '0; ng = 0;
        for (int i = 0; i < 5; i++) begin gidx[i] = -1; gcyc[i] = 0; end
        for (int c = 0; c < 12; c++) begin
            step();
            if (gnt != '0 && prev == '0 && ng < 5) begin
                gidx[ng] = onehot_idx(gnt);
                gcyc[ng] = cyc;
                ng++;
            end
            prev = gnt;
        end
        idle_inputs();
        step();
        check("rr_count", 64'(ng), 64'd5);
        for (int i = 0; i < 5; i++) check("rr_order", 64'(gidx[i]), 64'(i % N));
        for (int i = 1; i < 5; i++) check("rr_gap", 64'(gcyc[i] - gcyc[i-1]), 64'd2);

        // Requester 1 write burst of 4 while requester 0 waits.
        do_reset();
        set_req(1, 1'b1, 1'b0, 18'h40);
        step();
        check("wb_gnt", 64'(gnt), 64'b0010);
        cnt = 0;
        for (int b = 0; b < 4; b++) begin
            set_req(0, 1'b0, 1'b1, 18'h80);
            last[1] = (b == 3);
            addr[1*AB +: AB] = 18'(18'h40 + b * 8);
            #1;
            if (gnt[1] && sram_cs && sram_we) cnt++;
            step();
        end
        req[1] = 1'b0;
        step();
        check("wb_beats", 64'(cnt), 64'd4);
        check("wb_next_gnt", 64'(gnt), 64'b0001);
        idle_inputs();
        step();
        step();

        // Requester 3 streams 20 beats with no last; requester 0 waits.
        do_reset();
        set_req(3, 1'b0, 1'b0, 18'h200);
        step();
        cnt = 0; done = 1'b0; saw_g0 = 1'b0;
        for (int b = 0; b < 20; b++) begin
            set_req(0, 1'b0, 1'b1, 18'h10);
            #1;
            if (!done) begin
                if (gnt[3] && sram_cs) cnt++;
                else if (!gnt[3]) done = 1'b1;
            end
            if (gnt[0]) saw_g0 = 1'b1;
            step();
        end
        idle_inputs();
        step();
        step();
        check("burst_beats", 64'(cnt), LIMIT ? 64'd16 : 64'd20);
        check("burst_other_gnt", 64'(saw_g0), 64'(LIMIT));

        // Reset during an accepted read beat of requester 2.
        do_reset();
        set_req(1, 1'b0, 1'b1, 18'h8);
        step();
        step();
        idle_inputs();
        step();
        set_req(2, 1'b0, 1'b0, 18'h300);
        step();
        check("ab_gnt", 64'(gnt), 64'b0100);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("ab_gnt_off", 64'(gnt), 64'd0);
        check("ab_rvalid_off", 64'(rvalid), 64'd0);
        check("ab_cs_off", 64'(sram_cs), 64'd0);
        for (int k = 0; k < N; k++) set_req(k, 1'b0, 1'b1, 18'(k));
        step();
        check("ab_ptr_restart", 64'(gnt), 64'b0001);
        idle_inputs();
        step();
        step();

        // Random traffic against the model.
        for (int c = 0; c < 1500; c++) begin
            rst = ($urandom_range(99) == 0);
            for (int k = 0; k < N; k++) begin
                req[k]            = ($urandom_range(99) < 70);
                we[k]             = 1'($urandom_range(1));
                last[k]           = ($urandom_range(99) < 25);
                addr[k*AB +: AB]  = 18'($urandom);
                wdata[k*64 +: 64] = {$urandom, $urandom};
                wstrb[k*8 +: 8]   = 8'($urandom);
            end
            step();
        end
        rst = 1'b0;
        idle_inputs();
        step();

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 Parameter NREQ, default 4: number of requesters sharing internal SRAM; legal range 2..8.
REQ-002 Parameter abits, default 18: byte-address width, equal to CFG_SRAM_LOG2_SIZE.
REQ-003 Parameter MAX_BEATS, default 16: forced-release burst length; legal range 2..256.
REQ-004 Port i_clk, input, 1: the single clock; all state updates on its rising edge.
REQ-005 Port i_rst, input, 1: reset; synchronous and active-high.
REQ-006 Port i_req, input, NREQ: per-requester access request; also qualifies each beat.
REQ-007 Port i_we, input, NREQ: per-requester write enable; 0 means read.
REQ-008 Port i_addr, input, NREQ*abits: per-requester address; requester k uses slice k.
REQ-009 Port i_wdata, input, NREQ*64: per-requester write data.
REQ-010 Port i_wstrb, input, NREQ*8: per-requester byte strobes.
REQ-011 Port i_last, input, NREQ: marks the final beat of a burst.
REQ-012 Port o_gnt, output, NREQ: one-hot grant, registered.
REQ-013 Port o_rvalid, output, NREQ: one-hot read-data-valid, registered.
REQ-014 Port o_rdata, output, 64: shared read data, valid only with o_rvalid.
REQ-015 Ports o_sram_cs (1), o_sram_we (1), o_sram_addr (abits), o_sram_wdata (64), o_sram_wstrb (8): outputs to the SRAM.
REQ-016 Port i_sram_rdata, input, 64: SRAM read data, returned 1 cycle after the cs cycle.

Function
REQ-017 The FSM shall have two states: IDLE and BUSY.
REQ-018 In IDLE with any i_req set, the arbiter shall pick the first set bit searching from rr_ptr upward, modulo NREQ.
REQ-019 It shall latch the winner into owner, go to BUSY, and assert o_gnt[owner] on the next cycle.
REQ-020 In BUSY, o_sram_cs shall equal i_req[owner] combinationally; we, addr, wdata and wstrb shall come from owner's slices.
REQ-021 A beat is accepted in any BUSY cycle with i_req[owner]=1; beat_cnt increments per accepted beat.
REQ-022 An accepted read beat in cycle N shall give o_rvalid[owner]=1 with o_rdata=i_sram_rdata in cycle N+1.
REQ-023 Release: return to IDLE on an accepted beat with i_last[owner]=1, or on a BUSY cycle with i_req[owner]=0.
REQ-024 On release, o_gnt shall drop the next cycle, rr_ptr shall become (owner+1) mod NREQ, and beat_cnt shall clear.
REQ-025 Minimum latency: request in IDLE at cycle N, grant and first beat at N+1, read data at N+2.
REQ-026 A release cycle plus the re-arbitration cycle gives a 1-cycle bubble in IDLE between owners.
REQ-027 Requests arriving while BUSY shall be held off and considered at the next IDLE.
REQ-028 Writes shall produce no o_rvalid.

Reset
REQ-029 On i_rst: state=IDLE, owner=0, rr_ptr=0, beat_cnt=0; o_gnt, o_rvalid, o_sram_cs and o_sram_we shall all be 0 the next cycle.
REQ-030 Reset mid-burst shall abort the burst, and any read response pending from the reset cycle shall be suppressed.

Configuration
REQ-031 With SRAM_ARB_BURST_LIMIT_EN defined, a BUSY owner shall also release on its MAX_BEATS-th accepted beat, even without i_last.
REQ-032 Without SRAM_ARB_BURST_LIMIT_EN, bursts are unbounded and release follows REQ-023 only.

Verification
REQ-033 Requester 2 issues a single read at 0x100 -> o_gnt=0b0100 one cycle later, o_sram_addr=0x100, o_rvalid[2] the following cycle with SRAM data.
REQ-034 All 4 requesters hold single-beat requests -> grants in order 0,1,2,3,0, each separated by one IDLE bubble.
REQ-035 Requester 1 runs a 4-beat write burst while requester 0 requests -> 4 cs/we beats to requester 1, then requester 0 is granted.
REQ-036 With the macro defined, requester 3 issues a 20-beat burst with no i_last -> release after beat 16 and another requester is granted; with the macro undefined, all 20 beats complete.
REQ-037 i_rst is asserted in the same cycle as an accepted read beat -> next cycle o_gnt=0, o_rvalid=0, o_sram_cs=0; rr_ptr restarts at 0.
